// File: rtl/player_ctrl.sv
// Player control: turns debounced button levels into frame-synchronous cannon
// positions, fire strobes and shot-ready flags for two players. All per-frame
// state advances on the clock edge that ends the vsync falling-edge cycle.

// One player's cannon: position, fire request/strobe and shot cooldown.
module player_ctrl_unit #(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 608,
   parameter int X_INIT   = 304,
   parameter int STEP     = 2,
   parameter int COOLDOWN = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ft_i,
   input  logic        enable_i,
   input  logic [1:0]  btn_i,
   input  logic        dir_i,
   output logic [10:0] x_o,
   output logic        fire_o,
   output logic        ready_o
);

   typedef enum logic [1:0] {ST_DIS, ST_RUN, ST_COOL} state_e;

   localparam logic signed [11:0] XMIN_S  = 12'(X_MIN);
   localparam logic signed [11:0] XMAX_S  = 12'(X_MAX);
   localparam logic signed [11:0] STEP_S  = 12'(STEP);
   localparam logic        [10:0] XINIT_V = 11'(X_INIT);
   localparam logic        [7:0]  CD_LOAD = 8'(COOLDOWN);

   state_e             state_q;
   logic [7:0]         cd_q;
   logic               req_q;
   logic               hist_q;
   logic               fire_q;
   logic               ready_q;
   logic [10:0]        x_q;
   logic [10:0]        x_d;
   logic signed [11:0] x_s;
   logic signed [11:0] mv_s;
   logic               rise;

   assign rise    = btn_i[0] & ~hist_q;
   assign x_o     = x_q;
   assign fire_o  = fire_q;
   assign ready_o = ready_q;

   // Candidate position for this frame, saturated at the legal bounds.
   always_comb begin
      x_s  = signed'({1'b0, x_q});
      mv_s = x_s;
      if (dir_i) begin
         mv_s = x_s + STEP_S;
         if (mv_s > XMAX_S) mv_s = XMAX_S;
      end else begin
         mv_s = x_s - STEP_S;
         if (mv_s < XMIN_S) mv_s = XMIN_S;
      end
      x_d = btn_i[1] ? mv_s[10:0] : x_q;
   end

   // Player FSM with registered outputs; disable always takes priority.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_DIS;
         cd_q    <= 8'd0;
         req_q   <= 1'b0;
         // NOTE: history resets high so a fire button held through reset
         // release is not seen as a fresh press.
         hist_q  <= 1'b1;
         fire_q  <= 1'b0;
         ready_q <= 1'b1;
         x_q     <= XINIT_V;
      end else begin
         hist_q <= btn_i[0];
         fire_q <= 1'b0;
         if (!enable_i) begin
            state_q <= ST_DIS;
            cd_q    <= 8'd0;
            req_q   <= 1'b0;
            ready_q <= 1'b1;
         end else begin
            case (state_q)
               ST_DIS: begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
               ST_RUN: begin
                  if (ft_i) begin
                     req_q <= 1'b0;
                     x_q   <= x_d;
                     if (req_q) begin
                        state_q <= ST_COOL;
                        cd_q    <= CD_LOAD;
                        fire_q  <= 1'b1;
                        ready_q <= 1'b0;
                     end
                  end else if (rise) begin
                     req_q <= 1'b1;
                  end
               end
               ST_COOL: begin
                  if (ft_i) begin
                     req_q <= 1'b0;
                     x_q   <= x_d;
                     cd_q  <= cd_q - 8'd1;
                     if (cd_q == 8'd1) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                     end
                  end else if (rise) begin
                     req_q <= 1'b1;
                  end
               end
               default: state_q <= ST_DIS;
            endcase
         end
      end
   end

endmodule

// Top level: frame-tick extraction from vsync plus two player instances.
module player_ctrl #(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 608,
   parameter int X_INIT   = 304,
   parameter int STEP     = 2,
   parameter int COOLDOWN = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vsync,
   input  logic        enable,
   input  logic [1:0]  btn1,
   input  logic        btn1_dir,
   input  logic [1:0]  btn2,
   input  logic        btn2_dir,
   output logic [10:0] p1_x,
   output logic [10:0] p2_x,
   output logic        p1_fire,
   output logic        p2_fire,
   output logic        p1_ready,
   output logic        p2_ready,
   output logic        frame_tick
);

   logic vsync_q;
   logic frame_tick_q;
   logic ft;

   assign ft         = vsync_q & ~vsync;
   assign frame_tick = frame_tick_q;

   // vsync history and the registered frame tick shown alongside new state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q      <= 1'b1;
         frame_tick_q <= 1'b0;
      end else begin
         vsync_q      <= vsync;
         frame_tick_q <= ft;
      end
   end

   player_ctrl_unit #(
      .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .STEP(STEP), .COOLDOWN(COOLDOWN)
   ) u_p1 (
      .clk(clk), .rst_n(reset), .ft_i(ft), .enable_i(enable),
      .btn_i(btn1), .dir_i(btn1_dir),
      .x_o(p1_x), .fire_o(p1_fire), .ready_o(p1_ready)
   );

   player_ctrl_unit #(
      .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .STEP(STEP), .COOLDOWN(COOLDOWN)
   ) u_p2 (
      .clk(clk), .rst_n(reset), .ft_i(ft), .enable_i(enable),
      .btn_i(btn2), .dir_i(btn2_dir),
      .x_o(p2_x), .fire_o(p2_fire), .ready_o(p2_ready)
   );

endmodule

// File: tb/tb_player_ctrl.sv
// Self-checking bench for player_ctrl: directed scenarios plus random button
// activity, compared every cycle against a frame-level behavioural model.
module tb_player_ctrl;

   localparam int X_MIN    = 0;
   localparam int X_MAX    = 608;
   localparam int X_INIT   = 304;
   localparam int STEP     = 2;
   localparam int COOLDOWN = 30;
   localparam int FR       = 20;   // clocks per frame

   logic        clk = 1'b0;
   logic        reset;
   logic        vsync;
   logic        enable;
   logic [1:0]  btn1, btn2;
   logic        btn1_dir, btn2_dir;
   logic [10:0] p1_x, p2_x;
   logic        p1_fire, p2_fire, p1_ready, p2_ready, frame_tick;

   int  checks = 0;
   int  errors = 0;
   bit  chk_en = 0;
   bit  stuck  = 0;
   int  ph     = 0;
   int  f1 = 0, f2 = 0;
   int  f1s, f2s, xs;

   player_ctrl dut (
      .clk(clk), .reset(reset), .vsync(vsync), .enable(enable),
      .btn1(btn1), .btn1_dir(btn1_dir), .btn2(btn2), .btn2_dir(btn2_dir),
      .p1_x(p1_x), .p2_x(p2_x), .p1_fire(p1_fire), .p2_fire(p2_fire),
      .p1_ready(p1_ready), .p2_ready(p2_ready), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // A player is "active" once enable has been seen high after being low;
   // it is cooling exactly while its remaining cooldown count is non-zero.
   int         m_x[2];
   int         m_cd[2];
   bit         m_req[2], m_hist[2], m_act[2], m_fire[2];
   bit         m_vq, m_tick, m_ft, m_rise;
   logic [1:0] m_b;
   logic       m_d;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_vq = 1; m_tick = 0;
         for (int p = 0; p < 2; p++) begin
            m_x[p] = X_INIT; m_cd[p] = 0; m_req[p] = 0;
            m_hist[p] = 1; m_act[p] = 0; m_fire[p] = 0;
         end
      end else begin
         m_ft   = m_vq && !vsync;
         m_vq   = vsync;
         m_tick = m_ft;
         for (int p = 0; p < 2; p++) begin
            m_b       = (p == 0) ? btn1 : btn2;
            m_d       = (p == 0) ? btn1_dir : btn2_dir;
            m_rise    = m_b[0] && !m_hist[p];
            m_hist[p] = m_b[0];
            m_fire[p] = 0;
            if (!enable) begin
               m_act[p] = 0; m_cd[p] = 0; m_req[p] = 0;
            end else if (!m_act[p]) begin
               m_act[p] = 1;
            end else if (m_ft) begin
               if (m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
               else if (m_req[p]) begin m_fire[p] = 1; m_cd[p] = COOLDOWN; end
               if (m_b[1]) begin
                  if (m_d) m_x[p] = (m_x[p] + STEP > X_MAX) ? X_MAX : m_x[p] + STEP;
                  else     m_x[p] = (m_x[p] - STEP < X_MIN) ? X_MIN : m_x[p] - STEP;
               end
               m_req[p] = 0;
            end else if (m_rise) begin
               m_req[p] = 1;
            end
         end
      end
   end

   // Compare process: all outputs against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("p1_x",       p1_x,       m_x[0]);
         check("p2_x",       p2_x,       m_x[1]);
         check("p1_fire",    p1_fire,    m_fire[0]);
         check("p2_fire",    p2_fire,    m_fire[1]);
         check("p1_ready",   p1_ready,   m_cd[0] == 0);
         check("p2_ready",   p2_ready,   m_cd[1] == 0);
         check("frame_tick", frame_tick, m_tick);
      end
   end

   // Strobe counters used by directed scenarios.
   always @(negedge clk) begin
      if (p1_fire) f1++;
      if (p2_fire) f2++;
   end

   // vsync generator: low for the last two clocks of every frame.
   initial begin
      vsync = 1'b1;
      forever begin
         for (int i = 0; i < FR; i++) begin
            @(negedge clk);
            ph = i;
            if (!stuck) vsync = (i >= FR - 2) ? 1'b0 : 1'b1;
         end
      end
   end

   task automatic frames(input int n);
      repeat (n * FR) @(negedge clk);
   endtask

   // Bounded wait until the generator reports frame phase k.
   task automatic wait_phase(input int k);
      for (int i = 0; i <= FR; i++) begin
         @(negedge clk); #1;
         if (ph == k) break;
      end
   endtask

   task automatic press1();
      wait_phase(5); btn1[0] = 1'b1;
      repeat (2) @(negedge clk); btn1[0] = 1'b0;
   endtask

   task automatic press2();
      wait_phase(5); btn2[0] = 1'b1;
      repeat (2) @(negedge clk); btn2[0] = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1;
      btn1 = 2'b00; btn2 = 2'b00; btn1_dir = 1'b0; btn2_dir = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_p1_x", p1_x, 304);
      check("rst_p2_x", p2_x, 304);
      check("rst_ready", {p1_ready, p2_ready}, 2'b11);
      check("rst_strobes", {p1_fire, p2_fire, frame_tick}, 3'b000);
      chk_en = 1;
      reset  = 1'b1;

      // Idle frames: positions hold at the initial value.
      frames(5);
      check("idle_p1_x", p1_x, 304);
      check("idle_p2_x", p2_x, 304);
      check("idle_ready", {p1_ready, p2_ready}, 2'b11);

      // P1 left to the wall.
      btn1 = 2'b10; btn1_dir = 1'b0;
      frames(160);
      check("left_p1_x", p1_x, 0);
      check("left_p2_x", p2_x, 304);
      btn1 = 2'b00;

      // P2 right to the wall.
      btn2 = 2'b10; btn2_dir = 1'b1;
      frames(200);
      check("right_p2_x", p2_x, 608);
      btn2 = 2'b00;

      // Single shot, cooldown, and a discarded press during cooldown.
      f1s = f1;
      press1();
      frames(1);
      check("shot_count", f1 - f1s, 1);
      check("shot_ready_low", p1_ready, 0);
      frames(9);
      press1();
      frames(17);
      check("cool_ready_low", p1_ready, 0);
      frames(5);
      check("cool_ready_back", p1_ready, 1);
      check("cool_no_repeat", f1 - f1s, 1);

      // Asynchronous reset mid-frame, with fire held through release.
      @(posedge clk); #2;
      btn1  = 2'b01;
      reset = 1'b0;
      #1;
      check("async_p1_x", p1_x, 304);
      check("async_p2_x", p2_x, 304);
      check("async_tick", frame_tick, 0);
      check("async_ready", {p1_ready, p2_ready}, 2'b11);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      f1s = f1;
      frames(100);
      check("hold_no_shot", f1 - f1s, 0);
      btn1 = 2'b00;
      frames(1);
      press1();
      frames(2);
      check("repress_shot", f1 - f1s, 1);

      // Disable during P2 cooldown while P2 moves.
      btn2 = 2'b00; btn2_dir = 1'b0;
      press2();
      btn2[1] = 1'b1;
      frames(3);
      check("dis_ready_low", p2_ready, 0);
      wait_phase(3);
      xs = p2_x;
      enable = 1'b0;
      frames(5);
      check("dis_x_frozen", p2_x, xs);
      check("dis_ready", p2_ready, 1);
      enable = 1'b1;
      frames(2);
      check("dis_ready_after", p2_ready, 1);

      // Enable falls on the same edge as the frame tick, with a pending shot.
      press2();
      wait_phase(FR - 2);
      xs = p2_x; f2s = f2;
      enable = 1'b0;
      frames(1);
      check("simul_no_shot", f2 - f2s, 0);
      check("simul_x_held", p2_x, xs);
      enable = 1'b1;
      btn2 = 2'b00;
      frames(1);

      // Random activity, including stuck-vsync stretches.
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) btn1 = 2'($urandom);
         if ($urandom_range(0, 15) == 0) btn2 = 2'($urandom);
         if ($urandom_range(0, 31) == 0) btn1_dir = 1'($urandom);
         if ($urandom_range(0, 31) == 0) btn2_dir = 1'($urandom);
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         if ($urandom_range(0, 399) == 0) stuck = ~stuck;
      end
      stuck = 0; enable = 1'b1; btn1 = 2'b00; btn2 = 2'b00;
      frames(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
